// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two core masters (inst, data), the arbiter and the memory port.
//   slave  : arbiter view (takes master requests and memory responses, drives m_* and master responses)
//   master : environment view (core masters and memory model)
interface mem_bus_arbiter_if;
  // instruction master
  logic [31:0] i_address;
  logic        i_read_enable;
  logic        i_wait_req;
  logic        i_valid;
  logic [31:0] i_read_data;
  // data master
  logic [31:0] d_address;
  logic [31:0] d_write_data;
  logic [3:0]  d_byte_enable;
  logic        d_read_enable;
  logic        d_write_enable;
  logic        d_wait_req;
  logic        d_valid;
  logic [31:0] d_read_data;
  // memory port
  logic [31:0] m_address;
  logic [31:0] m_write_data;
  logic [3:0]  m_byte_enable;
  logic        m_read_enable;
  logic        m_write_enable;
  logic        m_wait_req;
  logic        m_valid;
  logic [31:0] m_read_data;

  modport slave (
    input  i_address, i_read_enable,
    output i_wait_req, i_valid, i_read_data,
    input  d_address, d_write_data, d_byte_enable, d_read_enable, d_write_enable,
    output d_wait_req, d_valid, d_read_data,
    output m_address, m_write_data, m_byte_enable, m_read_enable, m_write_enable,
    input  m_wait_req, m_valid, m_read_data
  );

  modport master (
    output i_address, i_read_enable,
    input  i_wait_req, i_valid, i_read_data,
    output d_address, d_write_data, d_byte_enable, d_read_enable, d_write_enable,
    input  d_wait_req, d_valid, d_read_data,
    input  m_address, m_write_data, m_byte_enable, m_read_enable, m_write_enable,
    output m_wait_req, m_valid, m_read_data
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master (inst/data) to one-slave memory bus arbiter.
// Requests are forwarded combinationally under round-robin arbitration with a
// grant lock while the memory stalls; an in-order ID FIFO routes read responses
// back to the issuing master.
// Ports:
//   clock          rising-edge clock
//   reset_n        asynchronous active-low reset
//   bus            mem_bus_arbiter_if.slave (inst, data and memory signals)
//   protocol_error sticky flag: memory response seen with no read outstanding
module mem_bus_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  mem_bus_arbiter_if.slave     bus,
  output logic                 protocol_error
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [1:0] ST_ARB    = 2'd0;
  localparam logic [1:0] ST_LOCK_I = 2'd1;
  localparam logic [1:0] ST_LOCK_D = 2'd2;

  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;

  logic [1:0]                 state_q, state_d;
  logic                       last_grant_q;
  logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]           count_q;
  logic [MAX_OUTSTANDING-1:0] id_q;

  logic full, empty;
  logic i_req, d_req;
  logic gnt_i, gnt_d;
  logic m_re, m_we;
  logic accept, push, pop, head_id;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Full check uses the registered count only, so a same-cycle response cannot unblock a read.
  assign full  = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign empty = (count_q == '0);

  // Eligible requests: blocked reads do not compete for the grant.
  assign i_req = bus.i_read_enable & ~full;
  assign d_req = (bus.d_read_enable & ~full) | bus.d_write_enable;

  // Grant selection and next state.
  always_comb begin
    state_d = state_q;
    gnt_i   = 1'b0;
    gnt_d   = 1'b0;
    case (state_q)
      ST_LOCK_I: begin
        gnt_i = i_req;
        if (!i_req || !bus.m_wait_req) state_d = ST_ARB;
      end
      ST_LOCK_D: begin
        gnt_d = d_req;
        if (!d_req || !bus.m_wait_req) state_d = ST_ARB;
      end
      default: begin
        if (i_req && d_req) begin
          gnt_i = (last_grant_q == ID_DATA);
          gnt_d = (last_grant_q == ID_INST);
        end else begin
          gnt_i = i_req;
          gnt_d = d_req;
        end
        if (gnt_i && bus.m_wait_req)      state_d = ST_LOCK_I;
        else if (gnt_d && bus.m_wait_req) state_d = ST_LOCK_D;
      end
    endcase
  end

  // Forwarded request; reset masks all handshakes immediately.
  assign m_re = reset_n & (gnt_i | (gnt_d & bus.d_read_enable));
  assign m_we = reset_n & gnt_d & bus.d_write_enable;

  assign bus.m_read_enable  = m_re;
  assign bus.m_write_enable = m_we;
  assign bus.m_address      = gnt_d ? bus.d_address : bus.i_address;
  assign bus.m_write_data   = bus.d_write_data;
  assign bus.m_byte_enable  = gnt_d ? bus.d_byte_enable : 4'hF;

  assign bus.i_wait_req = ~(reset_n & gnt_i & ~bus.m_wait_req);
  assign bus.d_wait_req = ~(reset_n & gnt_d & ~bus.m_wait_req);

  assign accept = (m_re | m_we) & ~bus.m_wait_req;
  assign push   = accept & m_re;
  assign pop    = bus.m_valid & ~empty;

  // Response routing from the head of the ID FIFO.
  assign head_id     = id_q[rd_ptr_q];
  assign bus.i_valid = reset_n & pop & (head_id == ID_INST);
  assign bus.d_valid = reset_n & pop & (head_id == ID_DATA);

  assign bus.i_read_data = bus.m_read_data;
  assign bus.d_read_data = bus.m_read_data;

  // Arbiter state and last grant.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_ARB;
      last_grant_q <= ID_DATA;
    end else begin
      state_q <= state_d;
      if (accept) last_grant_q <= gnt_d;
    end
  end

  // ID FIFO: pointers wrap modulo depth, count tracks occupancy separately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      id_q     <= '0;
    end else begin
      if (push) begin
        id_q[wr_ptr_q] <= gnt_d;
        wr_ptr_q       <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky error on an unsolicited response.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      protocol_error <= 1'b0;
    end else if (bus.m_valid && empty) begin
      protocol_error <= 1'b1;
    end
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master, one-slave bus arbiter that lets the core's instruction-fetch port and data port share a single memory port. Requests are forwarded combinationally under round-robin arbitration. The block tracks outstanding reads in an in-order ID FIFO so each returned `valid`/read-data beat is routed to the master that issued it. It sits between `toplevel`'s `inst_*`/`bus_*` ports and the memory model or interconnect.

## Interface
- `MAX_OUTSTANDING`, default 4: maximum accepted-but-unanswered reads, 1..16.
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `i_address`  in  32  instruction fetch address.
- `i_read_enable`  in  1  instruction read request.
- `i_wait_req`  out  1  instruction request not accepted this cycle.
- `i_valid`  out  1  instruction read data valid.
- `i_read_data`  out  32  instruction read data.
- `d_address`  in  32  data address.
- `d_write_data`  in  32  data write data.
- `d_byte_enable`  in  4  data byte lanes.
- `d_read_enable`  in  1  data read request.
- `d_write_enable`  in  1  data write request; never asserted together with `d_read_enable`.
- `d_wait_req`  out  1  data request not accepted this cycle.
- `d_valid`  out  1  data read data valid.
- `d_read_data`  out  32  data read data.
- `m_address`, `m_write_data`  out  32  forwarded address and write data.
- `m_byte_enable`  out  4  forwarded byte lanes; 4'b1111 for instruction reads.
- `m_read_enable`, `m_write_enable`  out  1  forwarded request.
- `m_wait_req`  in  1  memory stall.
- `m_valid`  in  1  memory read response.
- `m_read_data`  in  32  memory read data.
- `protocol_error`  out  1  sticky; set when `m_valid` arrives with no read outstanding.

## Operation
- A transfer is accepted in a cycle when `m_read_enable|m_write_enable` is high and `m_wait_req` is low.
- Arbiter FSM states:
  - ARB: grant is computed combinationally.
    - Only one master requesting: that master wins.
    - Both requesting: the master not in `last_grant` wins. `last_grant` resets to DATA, so the instruction port wins the first tie.
  - LOCK_I / LOCK_D: entered from ARB when the granted request is stalled (`m_wait_req`=1). Grant is held on that master and the other master is ignored. Return to ARB on acceptance.
- `last_grant` updates only on an accepted transfer.
- The losing master sees `*_wait_req`=1. The granted master sees `m_wait_req`.
- Full gating: reads are blocked when outstanding count == `MAX_OUTSTANDING`.
  - `m_read_enable` is forced low and the requester's `*_wait_req` is 1.
  - This holds even if `m_valid` is high in the same cycle. The full check uses the registered count only.
  - Writes are unaffected by the full condition.
- A blocked read does not take the grant. If the other master is requesting a write, that write is granted instead.
- ID FIFO behaviour:
  - Each accepted read pushes a 1-bit ID (0=inst, 1=data).
  - Each `m_valid` pops the head.
  - `i_valid` = `m_valid` & head==0; `d_valid` = `m_valid` & head==1.
  - `i_read_data` = `d_read_data` = `m_read_data` unconditionally.
- Simultaneous push and pop: count is unchanged; the head advances and the new ID is written at the tail.
- Wrap-around: read/write pointers are modulo `MAX_OUTSTANDING`. The count is a separate register of width clog2(`MAX_OUTSTANDING`+1).
- `m_valid` with count 0: no pop, no master valid, `protocol_error` set until reset.

## Timing
- Request path is combinational: zero added latency from master request to `m_*`.
- Response path is combinational: zero added latency from `m_valid` to `*_valid`.
- State, pointers, count, `last_grant` and `protocol_error` update on the rising `clock` edge.
- While `reset_n`=0 (asynchronous, checked before the clock):
  - FSM=ARB, count=0, pointers=0, `last_grant`=DATA, `protocol_error`=0.
  - `m_read_enable`, `m_write_enable`, `i_valid`, `d_valid` forced 0.
  - `i_wait_req` and `d_wait_req` forced 1.
- Reset mid-operation discards outstanding IDs. Responses arriving after reset release set `protocol_error`.

## Test plan
- Inst-only read at 0x100, memory responds 2 cycles later with 0x00000013 -> `i_valid` pulses once with 0x00000013; `d_valid` stays 0.
- Both masters issue reads in the same cycle from reset -> inst is granted first, data next cycle. Responses A then B return as `i_valid`(A) then `d_valid`(B).
- Data write to 0xfffffff0 (data 1, BE 4'hF) stalled 3 cycles by `m_wait_req` while inst requests -> FSM holds LOCK_D; inst `i_wait_req`=1 throughout; write accepted on cycle 4, then inst granted.
- `MAX_OUTSTANDING`=4, 4 inst reads accepted, no responses:
  - 5th read -> `m_read_enable`=0, `i_wait_req`=1.
  - A concurrent data write -> still accepted.
  - One response arrives -> the next cycle the stalled read is accepted.
- Interleaved traffic of 20 reads covers pointer wrap -> every response routed per issue order.
- `m_valid` with count 0 -> no master valid; `protocol_error`=1 until `reset_n` asserted.
- `reset_n` dropped with 2 reads outstanding -> outputs at reset values immediately, count 0 after release.
